// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares the single-ported memory between fetch and load/store
// Optional MEM_ARB_RR_EN selects round-robin; default is fixed data priority.
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 3'd0
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 3'd4
`endif

module mem_arbiter (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    i_if_req_valid,
    input  logic [`ADDR_W-1:0]      i_if_req_addr,
    output logic                    o_if_req_ready,
    output logic                    o_if_res_valid,
    output logic [`WORD_W-1:0]      o_if_res_data,
    output logic [`MEM_CODE_W-1:0]  o_if_res_code,
    input  logic                    i_dm_req_valid,
    input  logic [`ADDR_W-1:0]      i_dm_req_addr,
    input  logic [`WORD_W-1:0]      i_dm_req_wr_data,
    input  logic                    i_dm_req_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_dm_req_count,
    output logic                    o_dm_req_ready,
    output logic                    o_dm_res_valid,
    output logic [`WORD_W-1:0]      o_dm_res_data,
    output logic [`MEM_CODE_W-1:0]  o_dm_res_code,
    output logic [`ADDR_W-1:0]      o_mem_req_addr,
    output logic [`WORD_W-1:0]      o_mem_req_wr_data,
    output logic                    o_mem_req_wr_en,
    output logic [`MEM_COUNT_W-1:0] o_mem_req_count,
    input  logic [`WORD_W-1:0]      i_mem_res_rd_data,
    input  logic [`MEM_CODE_W-1:0]  i_mem_res_code
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t state_q;
    logic   owner_dm_q;
    logic   grant_dm;
    logic   accept;

`ifdef MEM_ARB_RR_EN
    logic ptr_dm_q;

    // With no requester the pointer still decides which ready is raised.
    always_comb begin
        if (i_dm_req_valid && i_if_req_valid) begin
            grant_dm = ptr_dm_q;
        end else if (i_dm_req_valid) begin
            grant_dm = 1'b1;
        end else if (i_if_req_valid) begin
            grant_dm = 1'b0;
        end else begin
            grant_dm = ptr_dm_q;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr_dm_q <= 1'b1;
        end else if (accept && i_dm_req_valid && i_if_req_valid) begin
            ptr_dm_q <= ~grant_dm;
        end
    end
`else
    assign grant_dm = i_dm_req_valid || !i_if_req_valid;
`endif

    assign o_dm_req_ready = (state_q == ST_IDLE) &&  grant_dm;
    assign o_if_req_ready = (state_q == ST_IDLE) && !grant_dm;
    assign accept         = (state_q == ST_IDLE) &&
                            (grant_dm ? i_dm_req_valid : i_if_req_valid);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q           <= ST_IDLE;
            owner_dm_q        <= 1'b0;
            o_mem_req_addr    <= '0;
            o_mem_req_wr_data <= '0;
            o_mem_req_wr_en   <= 1'b0;
            o_mem_req_count   <= `MEM_COUNT_NONE;
            o_if_res_valid    <= 1'b0;
            o_if_res_data     <= '0;
            o_if_res_code     <= '0;
            o_dm_res_valid    <= 1'b0;
            o_dm_res_data     <= '0;
            o_dm_res_code     <= '0;
        end else begin
            o_if_res_valid <= 1'b0;
            o_dm_res_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_dm_q <= grant_dm;
                        state_q    <= ST_ISSUE;
                        if (grant_dm) begin
                            o_mem_req_addr    <= i_dm_req_addr;
                            o_mem_req_wr_data <= i_dm_req_wr_data;
                            o_mem_req_wr_en   <= i_dm_req_wr_en;
                            o_mem_req_count   <= i_dm_req_count;
                        end else begin
                            o_mem_req_addr    <= i_if_req_addr;
                            o_mem_req_wr_data <= '0;
                            o_mem_req_wr_en   <= 1'b0;
                            o_mem_req_count   <= `MEM_COUNT_WORD;
                        end
                    end
                end
                ST_ISSUE: begin
                    // The request bus is only ever presented for a single cycle.
                    o_mem_req_addr    <= '0;
                    o_mem_req_wr_data <= '0;
                    o_mem_req_wr_en   <= 1'b0;
                    o_mem_req_count   <= `MEM_COUNT_NONE;
                    state_q           <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (owner_dm_q) begin
                        o_dm_res_valid <= 1'b1;
                        o_dm_res_data  <= i_mem_res_rd_data;
                        o_dm_res_code  <= i_mem_res_code;
                    end else begin
                        o_if_res_valid <= 1'b1;
                        o_if_res_data  <= i_mem_res_rd_data;
                        o_if_res_code  <= i_mem_res_code;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory and byte-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam logic [2:0] C_NONE = 3'd0, C_BYTE = 3'd1, C_HALF = 3'd2, C_WORD = 3'd4;
    localparam logic [2:0] K_READ = 3'd1, K_WRITE = 3'd2, K_MISAL = 3'd3, K_OOB = 3'd4, K_INVAL = 3'd5;
    localparam int WORDS = 64;
    localparam int BYTES = WORDS * 4;

    logic        clk = 1'b0;
    logic        areset;
    logic        if_valid, if_ready, if_res_valid;
    logic [31:0] if_addr, if_res_data;
    logic [2:0]  if_res_code;
    logic        dm_valid, dm_wr, dm_ready, dm_res_valid;
    logic [31:0] dm_addr, dm_wdata, dm_res_data;
    logic [2:0]  dm_cnt, dm_res_code;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wr;
    logic [2:0]  mem_cnt;
    logic [31:0] mem_rd = '0;
    logic [2:0]  mem_code = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] sim_mem [0:WORDS-1];
    logic [7:0]  ref_mem [0:BYTES-1];

    mem_arbiter dut (
        .clk(clk), .areset(areset),
        .i_if_req_valid(if_valid), .i_if_req_addr(if_addr), .o_if_req_ready(if_ready),
        .o_if_res_valid(if_res_valid), .o_if_res_data(if_res_data), .o_if_res_code(if_res_code),
        .i_dm_req_valid(dm_valid), .i_dm_req_addr(dm_addr), .i_dm_req_wr_data(dm_wdata),
        .i_dm_req_wr_en(dm_wr), .i_dm_req_count(dm_cnt), .o_dm_req_ready(dm_ready),
        .o_dm_res_valid(dm_res_valid), .o_dm_res_data(dm_res_data), .o_dm_res_code(dm_res_code),
        .o_mem_req_addr(mem_addr), .o_mem_req_wr_data(mem_wdata), .o_mem_req_wr_en(mem_wr),
        .o_mem_req_count(mem_cnt), .i_mem_res_rd_data(mem_rd), .i_mem_res_code(mem_code)
    );

    always #5 clk = ~clk;

    // Registered single-port memory: word array, response one cycle after the request.
    always @(posedge clk) begin : mem_model
        int n;
        int sh;
        logic [31:0] w;
        n = int'(mem_cnt);
        if (!(n == 1 || n == 2 || n == 4)) begin
            mem_code <= K_INVAL; mem_rd <= '0;
        end else if ((mem_addr & (n - 1)) != 0) begin
            mem_code <= K_MISAL; mem_rd <= '0;
        end else if (mem_addr >= BYTES) begin
            mem_code <= K_OOB; mem_rd <= '0;
        end else begin
            sh = 8 * int'(mem_addr[1:0]);
            w  = sim_mem[mem_addr[7:2]];
            if (mem_wr) begin
                for (int b = 0; b < n; b++) w[sh + 8*b +: 8] = mem_wdata[8*b +: 8];
                sim_mem[mem_addr[7:2]] = w;
                mem_code <= K_WRITE; mem_rd <= '0;
            end else begin
                w = w >> sh;
                mem_rd   <= (n == 4) ? w : (w & ((32'h1 << (8*n)) - 32'h1));
                mem_code <= K_READ;
            end
        end
    end

    // Reference: byte-addressed memory, little-endian, checked in the memory's rule order.
    function automatic void ref_access(input logic [31:0] a, input logic [2:0] c, input logic wr,
                                       input logic [31:0] wd, output logic [2:0] code,
                                       output logic [31:0] data);
        int n;
        n = int'(c);
        data = '0;
        if (n != 1 && n != 2 && n != 4) code = K_INVAL;
        else if (a % n != 0) code = K_MISAL;
        else if (a + n > BYTES) code = K_OOB;
        else if (wr) begin
            for (int b = 0; b < n; b++) ref_mem[a + b] = wd[8*b +: 8];
            code = K_WRITE;
        end else begin
            for (int b = 0; b < n; b++) data[8*b +: 8] = ref_mem[a + b];
            code = K_READ;
        end
    endfunction

    typedef struct {
        bit          acc;
        int          waitc;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        logic        b_wr;
        logic [2:0]  b_cnt;
        logic [2:0]  b_cnt2;
        logic        rv;
        logic        other_rv;
        logic [31:0] rdata;
        logic [2:0]  rcode;
        logic        rv_after;
    } obs_t;

    // Drives one request on one port and records what the DUT did; starts and ends on a negedge.
    task automatic xact(input bit dm, input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic [2:0] c, output obs_t o);
        o = '{default: 0};
        if (dm) begin
            dm_valid = 1'b1; dm_addr = a; dm_wdata = wd; dm_wr = wr; dm_cnt = c;
        end else begin
            if_valid = 1'b1; if_addr = a;
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            if (dm ? dm_ready : if_ready) begin o.acc = 1'b1; o.waitc = i; break; end
            @(negedge clk);
        end
        @(negedge clk);
        dm_valid = 1'b0; if_valid = 1'b0;
        if (o.acc) begin
            o.b_addr = mem_addr; o.b_wdata = mem_wdata; o.b_wr = mem_wr; o.b_cnt = mem_cnt;
            @(negedge clk);
            o.b_cnt2 = mem_cnt;
            @(negedge clk);
            o.rv       = dm ? dm_res_valid : if_res_valid;
            o.other_rv = dm ? if_res_valid : dm_res_valid;
            o.rdata    = dm ? dm_res_data : if_res_data;
            o.rcode    = dm ? dm_res_code : if_res_code;
            @(negedge clk);
            o.rv_after = dm ? dm_res_valid : if_res_valid;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        @(negedge clk); #1;
        checks++; if (dm_ready !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: dm=%b if=%b want dm=1 if=0", dm_ready, if_ready); end
        checks++; if (mem_cnt !== C_NONE || mem_addr !== 0 || mem_wr !== 0 || mem_wdata !== 0) begin errors++; $display("FAIL reset_membus: cnt=%0d addr=%h wr=%b wd=%h want all 0", mem_cnt, mem_addr, mem_wr, mem_wdata); end
        checks++; if (if_res_valid !== 0 || dm_res_valid !== 0 || if_res_data !== 0 || dm_res_data !== 0 || if_res_code !== 0 || dm_res_code !== 0) begin errors++; $display("FAIL reset_res: ifv=%b dmv=%b ifd=%h dmd=%h ifc=%0d dmc=%0d want all 0", if_res_valid, dm_res_valid, if_res_data, dm_res_data, if_res_code, dm_res_code); end
        if_valid = 1'b1; #1;
        checks++; if (if_ready !== 1'b1 || dm_ready !== 1'b0) begin errors++; $display("FAIL single_if_grant: if=%b dm=%b want if=1 dm=0", if_ready, dm_ready); end
        @(negedge clk);
        if_valid = 1'b0; areset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        obs_t o;
        xact(1'b0, 32'h10, 32'h0, 1'b0, C_WORD, o);
        checks++; if (!o.acc || o.waitc != 0) begin errors++; $display("FAIL fetch_accept: acc=%0d wait=%0d want 1/0", o.acc, o.waitc); end
        checks++; if (o.b_addr !== 32'h10 || o.b_cnt !== C_WORD || o.b_wr !== 0 || o.b_wdata !== 0) begin errors++; $display("FAIL fetch_bus: addr=%h cnt=%0d wr=%b wd=%h want 10/4/0/0", o.b_addr, o.b_cnt, o.b_wr, o.b_wdata); end
        checks++; if (o.b_cnt2 !== C_NONE) begin errors++; $display("FAIL fetch_bus_one_cycle: cnt=%0d want 0", o.b_cnt2); end
        checks++; if (o.rv !== 1 || o.other_rv !== 0) begin errors++; $display("FAIL fetch_strobe: if=%b dm=%b want 1/0", o.rv, o.other_rv); end
        checks++; if (o.rdata !== 32'hDEADBEEF || o.rcode !== K_READ) begin errors++; $display("FAIL fetch_data: data=%h code=%0d want deadbeef/%0d", o.rdata, o.rcode, K_READ); end
        checks++; if (o.rv_after !== 0 || if_res_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_pulse_hold: v=%b data=%h want 0/deadbeef", o.rv_after, if_res_data); end
    endtask

    task automatic test_store_load();
        obs_t o;
        logic [2:0] ec;
        logic [31:0] ed;
        ref_access(32'h21, C_BYTE, 1'b1, 32'h000000AB, ec, ed);
        xact(1'b1, 32'h21, 32'h000000AB, 1'b1, C_BYTE, o);
        checks++; if (o.b_wr !== 1 || o.b_cnt !== C_BYTE || o.b_wdata !== 32'hAB) begin errors++; $display("FAIL store_bus: wr=%b cnt=%0d wd=%h want 1/1/ab", o.b_wr, o.b_cnt, o.b_wdata); end
        checks++; if (o.rv !== 1 || o.rcode !== K_WRITE) begin errors++; $display("FAIL store_code: v=%b code=%0d want 1/%0d", o.rv, o.rcode, K_WRITE); end
        ref_access(32'h20, C_HALF, 1'b0, 32'h0, ec, ed);
        xact(1'b1, 32'h20, 32'h0, 1'b0, C_HALF, o);
        checks++; if (o.rv !== 1 || o.rdata !== 32'h0000AB00 || o.rcode !== K_READ) begin errors++; $display("FAIL half_load: v=%b data=%h code=%0d want 1/0000ab00/%0d", o.rv, o.rdata, o.rcode, K_READ); end
    endtask

    task automatic test_errors();
        obs_t o;
        xact(1'b1, 32'h22, 32'h0, 1'b0, C_WORD, o);
        checks++; if (o.rcode !== K_MISAL || o.rdata !== 0) begin errors++; $display("FAIL misaligned: code=%0d data=%h want %0d/0", o.rcode, o.rdata, K_MISAL); end
        xact(1'b1, 32'h100, 32'h0, 1'b0, C_WORD, o);
        checks++; if (o.rcode !== K_OOB) begin errors++; $display("FAIL out_of_bounds: code=%0d want %0d", o.rcode, K_OOB); end
        xact(1'b1, 32'h8, 32'h0, 1'b0, C_NONE, o);
        checks++; if (!o.acc || o.b_cnt !== C_NONE || o.rv !== 1 || o.rcode !== K_INVAL) begin errors++; $display("FAIL count_none: acc=%0d cnt=%0d v=%b code=%0d want 1/0/1/%0d", o.acc, o.b_cnt, o.rv, o.rcode, K_INVAL); end
    endtask

    task automatic test_backpressure();
        logic [2:0] ec;
        logic [31:0] ed, wd;
        wd = $urandom;
        ref_access(32'h30, C_WORD, 1'b1, wd, ec, ed);
        dm_valid = 1'b1; dm_addr = 32'h30; dm_wdata = wd; dm_wr = 1'b1; dm_cnt = C_WORD; #1;
        checks++; if (dm_ready !== 1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", dm_ready); end
        @(negedge clk);
        dm_valid = 1'b0; if_valid = 1'b1; if_addr = 32'h30; #1;
        checks++; if (if_ready !== 0 || dm_ready !== 0) begin errors++; $display("FAIL bp_issue_ready: if=%b dm=%b want 0/0", if_ready, dm_ready); end
        @(negedge clk); #1;
        checks++; if (if_ready !== 0 || dm_ready !== 0) begin errors++; $display("FAIL bp_capture_ready: if=%b dm=%b want 0/0", if_ready, dm_ready); end
        @(negedge clk); #1;
        checks++; if (if_ready !== 1 || dm_res_valid !== 1 || dm_res_code !== K_WRITE) begin errors++; $display("FAIL bp_reaccept: ready=%b dmv=%b code=%0d want 1/1/%0d", if_ready, dm_res_valid, dm_res_code, K_WRITE); end
        @(negedge clk);
        if_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        ref_access(32'h30, C_WORD, 1'b0, 32'h0, ec, ed);
        checks++; if (if_res_valid !== 1 || if_res_data !== ed || if_res_code !== K_READ) begin errors++; $display("FAIL bp_fetch_result: v=%b data=%h code=%0d want 1/%h/%0d", if_res_valid, if_res_data, if_res_code, ed, K_READ); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit gseq[6];
        int gat[6];
        int gcount;
        bit exp_dm;
        gcount = 0;
        areset = 1'b1; @(negedge clk); areset = 1'b0;
        dm_valid = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h0; dm_wr = 1'b0; dm_cnt = C_WORD;
        if_valid = 1'b1; if_addr = 32'h44;
        for (int n = 0; n < 40 && gcount < 6; n++) begin
            #1;
            if (gcount > 0 && n == gat[gcount-1] + 3) begin
                checks++; if ((gseq[gcount-1] ? dm_res_valid : if_res_valid) !== 1 || (gseq[gcount-1] ? if_res_valid : dm_res_valid) !== 0) begin errors++; $display("FAIL contend_strobe_%0d: dmv=%b ifv=%b owner_dm=%0d", gcount-1, dm_res_valid, if_res_valid, gseq[gcount-1]); end
            end
            if (dm_ready || if_ready) begin
                checks++; if (dm_ready && if_ready) begin errors++; $display("FAIL contend_both_ready: dm=%b if=%b want one", dm_ready, if_ready); end
                gseq[gcount] = dm_ready;
                gat[gcount]  = n;
                if (gcount > 0) begin
                    checks++; if (n - gat[gcount-1] != 3) begin errors++; $display("FAIL contend_spacing_%0d: got %0d cycles want 3", gcount, n - gat[gcount-1]); end
                end
                gcount++;
            end
            @(negedge clk);
        end
        dm_valid = 1'b0; if_valid = 1'b0;
        checks++; if (gcount != 6) begin errors++; $display("FAIL contend_grants: got %0d grants want 6", gcount); end
        for (int i = 0; i < gcount; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_dm = (i % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            checks++; if (gseq[i] != exp_dm) begin errors++; $display("FAIL contend_grant_%0d: dm=%0d want %0d", i, gseq[i], exp_dm); end
        end
        @(negedge clk); @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic [2:0] ec;
        logic [31:0] ed;
        bit seen;
        dm_valid = 1'b1; dm_addr = 32'h8; dm_wr = 1'b0; dm_cnt = C_WORD; dm_wdata = 32'h0;
        @(negedge clk);
        dm_valid = 1'b0; #1;
        checks++; if (mem_cnt !== C_WORD) begin errors++; $display("FAIL mid_issue_bus: cnt=%0d want 4", mem_cnt); end
        areset = 1'b1; #1;
        checks++; if (mem_cnt !== C_NONE || mem_addr !== 0 || dm_ready !== 1 || dm_res_code !== 0) begin errors++; $display("FAIL mid_reset_outputs: cnt=%0d addr=%h ready=%b code=%0d want 0/0/1/0", mem_cnt, mem_addr, dm_ready, dm_res_code); end
        @(negedge clk);
        areset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dm_res_valid !== 0 || if_res_valid !== 0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_reset_no_strobe: strobe seen=1 want 0"); end
        ref_access(32'h10, C_HALF, 1'b0, 32'h0, ec, ed);
        xact(1'b1, 32'h10, 32'h0, 1'b0, C_HALF, o);
        checks++; if (o.rv !== 1 || o.rdata !== ed || o.rcode !== ec) begin errors++; $display("FAIL mid_reset_after: v=%b data=%h code=%0d want 1/%h/%0d", o.rv, o.rdata, o.rcode, ed, ec); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0] cnts [6];
        logic [2:0] c, ec;
        logic [31:0] a, wd, ed;
        logic wr;
        bit dm;
        cnts = '{C_BYTE, C_HALF, C_WORD, C_WORD, C_NONE, 3'd3};
        for (int it = 0; it < 40; it++) begin
            dm = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, BYTES + 15));
            if (dm) begin
                c = cnts[$urandom_range(0, 5)]; wr = 1'($urandom_range(0, 1)); wd = $urandom;
            end else begin
                c = C_WORD; wr = 1'b0; wd = 32'h0;
            end
            ref_access(a, c, wr, wd, ec, ed);
            xact(dm, a, wd, wr, c, o);
            checks++; if (!o.acc || o.b_addr !== a || o.b_cnt !== c || o.b_wr !== wr || o.b_wdata !== wd || o.b_cnt2 !== C_NONE) begin errors++; $display("FAIL rand_bus_%0d: acc=%0d addr=%h cnt=%0d wr=%b wd=%h cnt2=%0d want %h/%0d/%b/%h/0", it, o.acc, o.b_addr, o.b_cnt, o.b_wr, o.b_wdata, o.b_cnt2, a, c, wr, wd); end
            checks++; if (o.rv !== 1 || o.other_rv !== 0 || o.rv_after !== 0) begin errors++; $display("FAIL rand_strobe_%0d: own=%b other=%b after=%b want 1/0/0", it, o.rv, o.other_rv, o.rv_after); end
            checks++; if (o.rdata !== ed || o.rcode !== ec) begin errors++; $display("FAIL rand_result_%0d: data=%h code=%0d want %h/%0d", it, o.rdata, o.rcode, ed, ec); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        areset = 1'b1;
        if_valid = 1'b0; if_addr = '0;
        dm_valid = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wr = 1'b0; dm_cnt = C_NONE;
        for (int i = 0; i < WORDS; i++) begin
            w = $urandom;
            if (i == 4) w = 32'hDEADBEEF;
            if (i == 8) w = 32'h0;
            sim_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_store_load();
        test_errors();
        test_backpressure();
        test_contention();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
